// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store memory master.
// Memop codes, FSM states, lane-size masks and a legality helper.
package lsu_pkg;

   localparam logic [2:0] MOP_B  = 3'b000;
   localparam logic [2:0] MOP_H  = 3'b001;
   localparam logic [2:0] MOP_W  = 3'b010;
   localparam logic [2:0] MOP_BU = 3'b100;
   localparam logic [2:0] MOP_HU = 3'b101;

   localparam logic [3:0] LANE_B = 4'b0001;
   localparam logic [3:0] LANE_H = 4'b0011;
   localparam logic [3:0] LANE_W = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_ACC1 = 2'd2,
      ST_FIN  = 2'd3
   } lsu_state_e;

   function automatic logic mop_legal(
      input logic       we,
      input logic [2:0] mop
   );
      logic ok;
      ok = 1'b0;
      unique case (1'b1)
         (mop == MOP_B),
         (mop == MOP_H),
         (mop == MOP_W):  ok = 1'b1;
         (mop == MOP_BU),
         (mop == MOP_HU): ok = ~we;
         default:         ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane steering for stores, merge/extend for loads.
// Purely combinational; the top picks which request fields feed it.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  memop,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] word_lo,
   input  logic [31:0] word_hi,
   output logic [7:0]  lanes8,
   output logic        split,
   output logic [31:0] wdata0,
   output logic [31:0] wdata1,
   output logic [31:0] ldata
);

   logic [3:0]  size_m;
   logic [4:0]  sh0;
   logic [5:0]  sh1;
   logic [31:0] merged;

   // Access size decode; low two memop bits carry the width.
   always_comb begin
      size_m = LANE_W;
      unique case (1'b1)
         (memop[1:0] == 2'b00): size_m = LANE_B;
         (memop[1:0] == 2'b01): size_m = LANE_H;
         default:               size_m = LANE_W;
      endcase
   end

   assign sh0    = {off, 3'b000};
   assign sh1    = 6'd32 - {1'b0, sh0};
   assign lanes8 = {4'b0000, size_m} << off;
   assign split  = |lanes8[7:4];
   assign wdata0 = wdata << sh0;
   assign wdata1 = wdata >> sh1;
   assign merged = 32'({word_hi, word_lo} >> sh0);

   // Sign or zero extend the right-justified load value.
   always_comb begin
      ldata = merged;
      unique case (1'b1)
         (memop == MOP_B):
            ldata = {{24{merged[7]}}, merged[7:0]};
         (memop == MOP_BU):
            ldata = {24'h0, merged[7:0]};
         (memop == MOP_H):
            ldata = {{16{merged[15]}}, merged[15:0]};
         (memop == MOP_HU):
            ldata = {16'h0, merged[15:0]};
         default:
            ldata = merged;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: MEM-stage load/store initiator for the data RAM.
// Splits misaligned accesses into two words; one response per request.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int MEM_AW = 15,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_memop,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_data,
   output logic              rsp_err,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [3:0]        mem_wmask,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [XLEN-1:0]   mem_rdata
);

   lsu_state_e state_q, state_d;

   logic              we_q, we_d;
   logic [2:0]        memop_q, memop_d;
   logic [1:0]        off_q, off_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [MEM_AW-1:0] w0_q, w0_d;
   logic              split_q, split_d;
   logic              err_q, err_d;
   logic [XLEN-1:0]   lo_q, lo_d;

   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wmask_q, mem_wmask_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_re_q, mem_re_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   logic [2:0]        a_memop;
   logic [1:0]        a_off;
   logic [XLEN-1:0]   a_wdata;
   logic [XLEN-1:0]   a_lo;
   logic [XLEN-1:0]   a_hi;
   logic [7:0]        a_lanes8;
   logic              a_split;
   logic [XLEN-1:0]   a_wdata0;
   logic [XLEN-1:0]   a_wdata1;
   logic [XLEN-1:0]   a_ldata;
   logic              req_legal;
   logic              addr_unused;

   assign addr_unused = ^req_addr[XLEN-1:MEM_AW+2];
   assign req_legal   = mop_legal(req_we, req_memop);

   // Aligner sees the live request at accept, captured fields after.
   always_comb begin
      a_memop = memop_q;
      a_off   = off_q;
      a_wdata = wdata_q;
      if (state_q == ST_IDLE) begin
         a_memop = req_memop;
         a_off   = req_addr[1:0];
         a_wdata = req_wdata;
      end
   end

   assign a_lo = split_q ? lo_q : mem_rdata;
   assign a_hi = split_q ? mem_rdata : '0;

   lsu_lane_align u_align (
      .memop   (a_memop),
      .off     (a_off),
      .wdata   (a_wdata),
      .word_lo (a_lo),
      .word_hi (a_hi),
      .lanes8  (a_lanes8),
      .split   (a_split),
      .wdata0  (a_wdata0),
      .wdata1  (a_wdata1),
      .ldata   (a_ldata)
   );

   // Next state plus next values of every registered output.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      memop_d     = memop_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      w0_d        = w0_q;
      split_d     = split_q;
      err_d       = err_q;
      lo_d        = lo_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = '0;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d       = req_we;
               memop_d    = req_memop;
               off_d      = req_addr[1:0];
               wdata_d    = req_wdata;
               w0_d       = req_addr[MEM_AW+1:2];
               split_d    = req_legal & a_split;
               err_d      = ~req_legal;
               mem_addr_d = req_addr[MEM_AW+1:2];
               if (req_legal && req_we) begin
                  mem_we_d    = 1'b1;
                  mem_wmask_d = a_lanes8[3:0];
                  mem_wdata_d = a_wdata0;
               end else if (req_legal) begin
                  mem_re_d = 1'b1;
               end
               state_d = ST_ACC0;
            end
         end
         ST_ACC0: begin
            state_d = ST_FIN;
            if (split_q) begin
               state_d    = ST_ACC1;
               mem_addr_d = w0_q + 1'b1;
               if (we_q) begin
                  mem_we_d    = 1'b1;
                  mem_wmask_d = a_lanes8[7:4];
                  mem_wdata_d = a_wdata1;
               end else begin
                  mem_re_d = 1'b1;
               end
            end
         end
         ST_ACC1: begin
            lo_d    = mem_rdata;
            state_d = ST_FIN;
         end
         ST_FIN: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_q;
            rsp_data_d  = (we_q | err_q) ? '0 : a_ldata;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, request capture and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         memop_q     <= '0;
         off_q       <= '0;
         wdata_q     <= '0;
         w0_q        <= '0;
         split_q     <= 1'b0;
         err_q       <= 1'b0;
         lo_q        <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         memop_q     <= memop_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         w0_q        <= w0_d;
         split_q     <= split_d;
         err_q       <= err_d;
         lo_q        <= lo_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wmask = mem_wmask_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: random and directed checks of lsu_mem_master.
// Byte-addressed reference memory predicts results and RAM strobes.
module tb_lsu_mem_master;

   localparam int MEM_AW = 15;
   localparam int BAW    = MEM_AW + 2;
   localparam int NW     = 1 << MEM_AW;
   localparam int NB     = 1 << BAW;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_memop;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_data;
   logic              rsp_err;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;
   logic              mem_we;
   logic              mem_re;
   logic [31:0]       mem_rdata;

   always #5 clk = ~clk;

   lsu_mem_master #(
      .MEM_AW (MEM_AW),
      .XLEN   (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_memop (req_memop),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [31:0] init_word(input int w);
      if (w == 'h40) return 32'h88776655;
      if (w == 'h41) return 32'hDDCCBBAA;
      return (32'(w) * 32'h9E3779B1) ^ 32'h0F1E2D3C;
   endfunction

   logic [31:0] ram [0:NW-1];
   logic        ram_init;

   // RAM: one-cycle read, byte-masked write, bulk preload.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int w = 0; w < NW; w++) ram[w] <= init_word(w);
      end else begin
         if (mem_re) mem_rdata <= ram[mem_addr];
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_wmask[b])
                  ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   logic [7:0] ref_b [0:NB-1];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int mop_bytes(input logic [2:0] mop);
      case (mop[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit ref_legal(input logic we,
                                    input logic [2:0] mop);
      case (mop)
         3'b000, 3'b001, 3'b010: return 1'b1;
         3'b100, 3'b101:         return !we;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] mop,
                                            input logic [BAW-1:0] a);
      logic [31:0] v;
      int n;
      v = '0;
      n = mop_bytes(mop);
      for (int i = 0; i < n; i++)
         v[8*i +: 8] = ref_b[(int'(a) + i) % NB];
      if (!mop[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!mop[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   function automatic logic [31:0] lane_bits(input logic [3:0] m);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
      return r;
   endfunction

   logic [31:0] last_data;
   int          last_k;
   logic        last_err;

   task automatic do_req(input logic        we,
                         input logic [2:0]  mop,
                         input logic [31:0] addr,
                         input logic [31:0] wd);
      int          off, n, k, nacc, lane;
      bit          legal, split, seen;
      logic [14:0] wa, wb;
      logic [3:0]  mask_exp [2];
      logic [31:0] wd_exp [2];
      logic [14:0] acc_addr [2];
      logic [3:0]  acc_mask [2];
      logic [31:0] acc_wd [2];
      logic [1:0]  acc_kind [2];
      int          acc_k [2];
      legal = ref_legal(we, mop);
      n     = mop_bytes(mop);
      off   = int'(addr[1:0]);
      split = legal && (off + n > 4);
      wa    = addr[BAW-1:2];
      wb    = wa + 15'd1;
      for (int j = 0; j < 2; j++) begin
         mask_exp[j] = '0;
         wd_exp[j]   = '0;
      end
      for (int i = 0; i < n; i++) begin
         lane = off + i;
         mask_exp[lane/4][lane%4]     = 1'b1;
         wd_exp[lane/4][8*(lane%4) +: 8] = wd[8*i +: 8];
      end
      check("req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_memop = mop;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_memop = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      nacc = 0;
      seen = 1'b0;
      k    = 0;
      last_k    = -1;
      last_data = '0;
      last_err  = 1'b0;
      while (!seen && k < 10) begin
         @(negedge clk);
         k++;
         if (mem_we || mem_re) begin
            if (nacc < 2) begin
               acc_addr[nacc] = mem_addr;
               acc_mask[nacc] = mem_wmask;
               acc_wd[nacc]   = mem_wdata;
               acc_kind[nacc] = {mem_we, mem_re};
               acc_k[nacc]    = k;
            end
            nacc++;
         end else begin
            check("wmask_idle", 32'(mem_wmask), 32'd0);
         end
         if (rsp_valid) begin
            seen      = 1'b1;
            last_k    = k;
            last_data = rsp_data;
            last_err  = rsp_err;
         end
      end
      check("rsp_seen", 32'(seen), 32'd1);
      check("rsp_cycle", last_k, split ? 4 : 3);
      check("rsp_err", 32'(last_err), 32'(!legal));
      check("rsp_data", last_data,
            (legal && !we) ? ref_load(mop, addr[BAW-1:0]) : 32'd0);
      check("acc_count", nacc, legal ? (split ? 2 : 1) : 0);
      for (int j = 0; j < 2 && j < nacc; j++) begin
         check("acc_addr", 32'(acc_addr[j]), 32'(j == 0 ? wa : wb));
         check("acc_cycle", acc_k[j], j + 1);
         check("acc_kind", 32'(acc_kind[j]), we ? 32'd2 : 32'd1);
         check("acc_mask", 32'(acc_mask[j]),
               we ? 32'(mask_exp[j]) : 32'd0);
         if (we)
            check("acc_wdata", acc_wd[j] & lane_bits(mask_exp[j]),
                  wd_exp[j]);
      end
      if (legal && we) begin
         for (int i = 0; i < n; i++)
            ref_b[(int'(addr[BAW-1:0]) + i) % NB] = wd[8*i +: 8];
      end
   endtask

   task automatic reset_mid_split();
      logic [31:0] addr;
      logic [31:0] wd;
      addr      = 32'h0000010B;
      wd        = 32'h0000CAFE;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_memop = 3'b001;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_c1_we", 32'(mem_we), 32'd1);
      @(negedge clk);
      check("rst_c2_we", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async_we", 32'(mem_we), 32'd0);
      check("rst_async_re", 32'(mem_re), 32'd0);
      check("rst_async_mask", 32'(mem_wmask), 32'd0);
      ref_b[int'(addr[BAW-1:0])] = wd[7:0];
      repeat (3) begin
         @(negedge clk);
         check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] word;
      logic [31:0] a;
      logic [2:0]  mop;
      logic        we;
      rst_n     = 1'b1;
      ram_init  = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_memop = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int w = 0; w < NW; w++) begin
         word = init_word(w);
         for (int b = 0; b < 4; b++) ref_b[4*w + b] = word[8*b +: 8];
      end
      #1 rst_n = 1'b0;
      #2;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_re", 32'(mem_re), 32'd0);
      check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      ram_init = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_req(1'b0, 3'b000, 32'h103, 32'h0);
      check("lb_103", last_data, 32'hFFFFFF88);
      do_req(1'b0, 3'b100, 32'h103, 32'h0);
      check("lbu_103", last_data, 32'h00000088);
      do_req(1'b0, 3'b101, 32'h102, 32'h0);
      check("lhu_102", last_data, 32'h00008877);
      do_req(1'b0, 3'b010, 32'h102, 32'h0);
      check("lw_102", last_data, 32'hBBAA8877);
      check("lw_102_cycle", last_k, 4);
      do_req(1'b1, 3'b010, 32'h100, 32'h11223344);
      check("sw_100_cycle", last_k, 3);
      do_req(1'b1, 3'b001, 32'h103, 32'h0000BEEF);
      do_req(1'b0, 3'b010, 32'h100, 32'h0);
      check("lw_after_sh", last_data, 32'hEF223344);
      do_req(1'b0, 3'b100, 32'h104, 32'h0);
      check("lbu_104", last_data, 32'h000000BE);
      do_req(1'b1, 3'b010, 32'h1FFFE, 32'hA1B2C3D4);
      do_req(1'b0, 3'b010, 32'h1FFFE, 32'h0);
      check("lw_wrap", last_data, 32'hA1B2C3D4);
      do_req(1'b0, 3'b111, 32'h100, 32'h0);
      check("illegal_err", 32'(last_err), 32'd1);
      do_req(1'b1, 3'b100, 32'h105, 32'h55);
      check("illegal_st_err", 32'(last_err), 32'd1);
      reset_mid_split();
      do_req(1'b0, 3'b101, 32'h10B, 32'h0);
      do_req(1'b0, 3'b100, 32'h10B, 32'h0);
      check("rst_word0_kept", last_data, 32'h000000FE);

      for (int t = 0; t < 400; t++) begin
         case ($urandom_range(0, 2))
            0:       a = 32'h100 + $urandom_range(0, 127);
            1:       a = 32'h1FFF0 + $urandom_range(0, 15);
            default: a = 32'($urandom_range(0, 15));
         endcase
         a[31:BAW] = 15'($urandom);
         we  = 1'($urandom);
         mop = 3'($urandom_range(0, 7));
         do_req(we, mop, a, $urandom);
      end

      for (int w = 0; w < NW; w++) begin
         if ((w >= 'h3C && w <= 'h61) || w >= NW - 4 || w < 5) begin
            word = {ref_b[4*w+3], ref_b[4*w+2],
                    ref_b[4*w+1], ref_b[4*w]};
            check("ram_final", ram[w], word);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
